// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - CCU ALU op sequencer: regfile operands -> ALU bus -> write-back + response.
// Optional sticky cc accumulator enabled by defining ALU_SEQ_STICKY_EN.
module alu_op_sequencer #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [AW-1:0]     cmd_sa,
  input  logic [AW-1:0]     cmd_sb,
  input  logic              cmd_use_imm,
  input  logic [DATA_W-1:0] cmd_imm,
  input  logic [AW-1:0]     cmd_dst,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_n,
  input  logic [DATA_W-1:0] alu_r,
  input  logic [3:0]        alu_cc,
  input  logic              alu_we,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [3:0]        rsp_cc,
  output logic              rsp_err,
  output logic [3:0]        status_cc,
  input  logic [AW-1:0]     rd_addr,
`ifdef ALU_SEQ_STICKY_EN
  input  logic              sticky_clr,
  output logic [3:0]        status_sticky,
`endif
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DRIVE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;

  logic [1:0]        state;
  logic [AW-1:0]     dst_q;
  logic              err_q;
  logic [DATA_W-1:0] regs [NREGS];
  logic              capture_ok;

  assign cmd_ready  = (state == IDLE);
  assign rd_data    = regs[rd_addr];
  assign capture_ok = (state == CAPTURE) && !err_q && alu_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      dst_q     <= '0;
      err_q     <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_n     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_cc    <= '0;
      rsp_err   <= 1'b0;
      status_cc <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          // Operands are read before any write-back, so sa==sb==dst sees the old value.
          if (cmd_valid) begin
            alu_a <= regs[cmd_sa];
            alu_b <= cmd_use_imm ? cmd_imm : regs[cmd_sb];
            alu_n <= cmd_op;
            dst_q <= cmd_dst;
            err_q <= cmd_op[3];
            state <= DRIVE;
          end
        end
        DRIVE: state <= CAPTURE;
        CAPTURE: begin
          state     <= IDLE;
          rsp_valid <= 1'b1;
          if (capture_ok) begin
            regs[dst_q] <= alu_r;
            status_cc   <= alu_cc;
            rsp_data    <= alu_r;
            rsp_cc      <= alu_cc;
            rsp_err     <= 1'b0;
          end else begin
            rsp_data <= '0;
            rsp_cc   <= '0;
            rsp_err  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_STICKY_EN
  always_ff @(posedge clk) begin
    if (reset || sticky_clr) status_sticky <= '0;
    else if (capture_ok)     status_sticky <= status_sticky | alu_cc;
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer with a behavioural ALU.
module tb_alu_op_sequencer;
  localparam int DATA_W = 8;
  localparam int NREGS  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_use_imm;
  logic [3:0] cmd_op;
  logic [1:0] cmd_sa, cmd_sb, cmd_dst, rd_addr;
  logic [7:0] cmd_imm, alu_a, alu_b, alu_r, rsp_data, rd_data;
  logic [3:0] alu_n, alu_cc, rsp_cc, status_cc;
  logic       alu_we, rsp_valid, rsp_err, kill_we;
`ifdef ALU_SEQ_STICKY_EN
  logic       sticky_clr;
  logic [3:0] status_sticky;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DATA_W(DATA_W), .NREGS(NREGS)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_sa(cmd_sa), .cmd_sb(cmd_sb), .cmd_use_imm(cmd_use_imm),
    .cmd_imm(cmd_imm), .cmd_dst(cmd_dst),
    .alu_a(alu_a), .alu_b(alu_b), .alu_n(alu_n),
    .alu_r(alu_r), .alu_cc(alu_cc), .alu_we(alu_we),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_cc(rsp_cc), .rsp_err(rsp_err),
    .status_cc(status_cc), .rd_addr(rd_addr),
`ifdef ALU_SEQ_STICKY_EN
    .sticky_clr(sticky_clr), .status_sticky(status_sticky),
`endif
    .rd_data(rd_data)
  );

  // Behavioural ALU: cc[0] carry/borrow/shifted-out bit, cc[1] zero, cc[2] a>=b or passA, cc[3] b>a or passB.
  typedef struct packed { logic [7:0] r; logic [3:0] cc; logic we; } alu_res_t;

  function automatic alu_res_t alu_fn(input logic [3:0] n, input logic [7:0] a, input logic [7:0] b);
    alu_res_t s;
    logic [8:0] w;
    s = '0;
    s.we = 1'b1;
    case (n)
      4'd0: begin w = {1'b0, a} + {1'b0, b}; s.r = w[7:0]; s.cc[0] = w[8]; end
      4'd1: begin w = {1'b0, a} - {1'b0, b}; s.r = w[7:0]; s.cc[0] = w[8]; end
      4'd2: begin s.r = {a[6:0], 1'b0}; s.cc[0] = a[7]; end
      4'd3: begin s.r = {1'b0, a[7:1]}; s.cc[0] = a[0]; end
      4'd4: begin s.r = a; s.cc[2] = 1'b1; end
      4'd5: begin s.r = b; s.cc[3] = 1'b1; end
      4'd6: begin s.r = (a >= b) ? a : b; s.cc[2] = (a >= b); s.cc[3] = (b > a); end
      4'd7: begin s.r = (a <= b) ? a : b; s.cc[2] = (a >= b); s.cc[3] = (b > a); end
      default: begin s.r = 8'hEE; s.cc = 4'hF; s.we = 1'b0; end
    endcase
    if (n < 4'd8) s.cc[1] = (s.r == 8'h00);
    return s;
  endfunction

  alu_res_t alu_now;
  always_comb alu_now = alu_fn(alu_n, alu_a, alu_b);
  assign alu_r  = alu_now.r;
  assign alu_cc = alu_now.cc;
  assign alu_we = alu_now.we & ~kill_we;

  logic [7:0] mregs [NREGS];
  logic [3:0] mstatus, mstick;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) mregs[i] = 8'h00;
    mstatus = 4'h0;
    mstick  = 4'h0;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic do_cmd(input logic [3:0] op, input logic [1:0] sa, input logic [1:0] sb,
                        input logic ui, input logic [7:0] imm, input logic [1:0] dst,
                        input logic kw, input logic sclr,
                        output logic [7:0] g_data, output logic [3:0] g_cc,
                        output logic g_err, output logic [7:0] g_rd);
    logic [7:0] a, b, old;
    alu_res_t e;
    logic ok;
    int n;
    cmd_valid = 1'b1; cmd_op = op; cmd_sa = sa; cmd_sb = sb;
    cmd_use_imm = ui; cmd_imm = imm; cmd_dst = dst;
    n = 0;
    while (!cmd_ready && n < 10) begin @(negedge clk); n++; end
    chk("accept_ready", cmd_ready, 1);
    a   = mregs[sa];
    b   = ui ? imm : mregs[sb];
    e   = alu_fn(op, a, b);
    ok  = !op[3] && e.we && !kw;
    old = mregs[dst];
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    kill_we = kw;
    chk("drive_ready", cmd_ready, 0);
    chk("drive_rsp_valid", rsp_valid, 0);
    chk("drive_alu_a", alu_a, a);
    chk("drive_alu_b", alu_b, b);
    chk("drive_alu_n", alu_n, op);
    @(negedge clk);
`ifdef ALU_SEQ_STICKY_EN
    sticky_clr = sclr;
`endif
    rd_addr = dst;
    #1;
    chk("capture_ready", cmd_ready, 0);
    chk("capture_rsp_valid", rsp_valid, 0);
    chk("capture_rd_old", rd_data, old);
    @(negedge clk);
    kill_we = 1'b0;
`ifdef ALU_SEQ_STICKY_EN
    sticky_clr = 1'b0;
`endif
    if (ok) begin
      mregs[dst] = e.r;
      mstatus = e.cc;
    end
    if (sclr) mstick = 4'h0;
    else if (ok) mstick = mstick | e.cc;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_err", rsp_err, !ok);
    chk("rsp_data", rsp_data, ok ? e.r : 8'h00);
    chk("rsp_cc", rsp_cc, ok ? e.cc : 4'h0);
    chk("status_cc", status_cc, mstatus);
    chk("rd_new", rd_data, mregs[dst]);
    chk("idle_ready", cmd_ready, 1);
    chk("idle_alu_n_held", alu_n, op);
`ifdef ALU_SEQ_STICKY_EN
    chk("status_sticky", status_sticky, mstick);
`endif
    g_data = rsp_data; g_cc = rsp_cc; g_err = rsp_err; g_rd = rd_data;
    @(negedge clk);
    chk("rsp_pulse_end", rsp_valid, 0);
  endtask

  typedef struct {
    logic [3:0] op; logic [1:0] sa; logic [1:0] sb; logic ui; logic [7:0] imm;
    logic [1:0] dst; logic kw; logic [7:0] e_data; logic [3:0] e_cc; logic e_err; logic [7:0] e_rd;
  } vec_t;

  vec_t tbl [18];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] gd, gr;
    logic [3:0] gc;
    logic ge;
    logic [3:0] rop;

    //             op   sa    sb    ui    imm    dst   kw    data   cc    err   rd
    tbl[0]  = '{4'd5, 2'd0, 2'd0, 1'b1, 8'h3C, 2'd1, 1'b0, 8'h3C, 4'h8, 1'b0, 8'h3C};
    tbl[1]  = '{4'd5, 2'd0, 2'd0, 1'b1, 8'hFF, 2'd1, 1'b0, 8'hFF, 4'h8, 1'b0, 8'hFF};
    tbl[2]  = '{4'd5, 2'd0, 2'd0, 1'b1, 8'h01, 2'd2, 1'b0, 8'h01, 4'h8, 1'b0, 8'h01};
    tbl[3]  = '{4'd0, 2'd1, 2'd2, 1'b0, 8'h00, 2'd3, 1'b0, 8'h00, 4'h3, 1'b0, 8'h00};
    tbl[4]  = '{4'd5, 2'd0, 2'd0, 1'b1, 8'h10, 2'd1, 1'b0, 8'h10, 4'h8, 1'b0, 8'h10};
    tbl[5]  = '{4'd5, 2'd0, 2'd0, 1'b1, 8'h20, 2'd2, 1'b0, 8'h20, 4'h8, 1'b0, 8'h20};
    tbl[6]  = '{4'd6, 2'd1, 2'd2, 1'b0, 8'h00, 2'd3, 1'b0, 8'h20, 4'h8, 1'b0, 8'h20};
    tbl[7]  = '{4'd7, 2'd1, 2'd2, 1'b0, 8'h00, 2'd3, 1'b0, 8'h10, 4'h8, 1'b0, 8'h10};
    tbl[8]  = '{4'd5, 2'd0, 2'd0, 1'b1, 8'h55, 2'd0, 1'b0, 8'h55, 4'h8, 1'b0, 8'h55};
    tbl[9]  = '{4'd9, 2'd0, 2'd0, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 4'h0, 1'b1, 8'h55};
    tbl[10] = '{4'd0, 2'd1, 2'd2, 1'b0, 8'h00, 2'd0, 1'b1, 8'h00, 4'h0, 1'b1, 8'h55};
    tbl[11] = '{4'd1, 2'd2, 2'd1, 1'b0, 8'h00, 2'd0, 1'b0, 8'h10, 4'h0, 1'b0, 8'h10};
    tbl[12] = '{4'd2, 2'd2, 2'd0, 1'b0, 8'h00, 2'd1, 1'b0, 8'h40, 4'h0, 1'b0, 8'h40};
    tbl[13] = '{4'd3, 2'd1, 2'd0, 1'b0, 8'h00, 2'd2, 1'b0, 8'h20, 4'h0, 1'b0, 8'h20};
    tbl[14] = '{4'd1, 2'd0, 2'd0, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 4'h2, 1'b0, 8'h00};
    tbl[15] = '{4'd4, 2'd3, 2'd0, 1'b0, 8'h00, 2'd3, 1'b0, 8'h10, 4'h4, 1'b0, 8'h10};
    tbl[16] = '{4'd1, 2'd0, 2'd2, 1'b0, 8'h00, 2'd1, 1'b0, 8'hE0, 4'h1, 1'b0, 8'hE0};
    tbl[17] = '{4'd2, 2'd1, 2'd0, 1'b0, 8'h00, 2'd2, 1'b0, 8'hC0, 4'h1, 1'b0, 8'hC0};

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_sa = '0; cmd_sb = '0;
    cmd_use_imm = 1'b0; cmd_imm = '0; cmd_dst = '0; rd_addr = '0; kill_we = 1'b0;
`ifdef ALU_SEQ_STICKY_EN
    sticky_clr = 1'b0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_ready", cmd_ready, 1);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_alu_n", alu_n, 0);
    chk("reset_alu_a", alu_a, 0);
    chk("reset_status", status_cc, 0);
    for (int i = 0; i < NREGS; i++) begin
      rd_addr = 2'(i);
      #1 chk("reset_regfile", rd_data, 0);
    end

    for (int i = 0; i < 18; i++) begin
      do_cmd(tbl[i].op, tbl[i].sa, tbl[i].sb, tbl[i].ui, tbl[i].imm, tbl[i].dst,
             tbl[i].kw, 1'b0, gd, gc, ge, gr);
      chk($sformatf("tbl%0d_data", i), gd, tbl[i].e_data);
      chk($sformatf("tbl%0d_cc", i), gc, tbl[i].e_cc);
      chk($sformatf("tbl%0d_err", i), ge, tbl[i].e_err);
      chk($sformatf("tbl%0d_rd", i), gr, tbl[i].e_rd);
    end

    // Command held valid while busy is accepted only in the next IDLE cycle.
    cmd_valid = 1'b1; cmd_op = 4'd5; cmd_use_imm = 1'b1; cmd_imm = 8'h11; cmd_dst = 2'd0;
    @(posedge clk);
    @(negedge clk);
    cmd_imm = 8'h22; cmd_dst = 2'd1;
    chk("b2b_busy1", cmd_ready, 0);
    @(negedge clk);
    chk("b2b_busy2", cmd_ready, 0);
    chk("b2b_alu_b_held", alu_b, 8'h11);
    @(negedge clk);
    chk("b2b_rsp1_valid", rsp_valid, 1);
    chk("b2b_rsp1_data", rsp_data, 8'h11);
    chk("b2b_ready", cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("b2b_second_accepted", alu_b, 8'h22);
    chk("b2b_rsp_gap", rsp_valid, 0);
    @(negedge clk);
    chk("b2b_rsp_gap2", rsp_valid, 0);
    @(negedge clk);
    chk("b2b_rsp2_valid", rsp_valid, 1);
    chk("b2b_rsp2_data", rsp_data, 8'h22);
    mregs[0] = 8'h11; mregs[1] = 8'h22; mstatus = 4'h8; mstick = mstick | 4'h8;
    @(negedge clk);

    for (int i = 0; i < 150; i++) begin
      rop = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      do_cmd(rop, 2'($urandom), 2'($urandom), 1'($urandom), 8'($urandom), 2'($urandom),
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0), gd, gc, ge, gr);
    end

`ifdef ALU_SEQ_STICKY_EN
    do_cmd(4'd5, 2'd0, 2'd0, 1'b1, 8'h01, 2'd0, 1'b0, 1'b1, gd, gc, ge, gr);
    chk("sticky_clear_wins", status_sticky, 0);
`endif

    // Reset during DRIVE aborts the op with no write-back and no response.
    mregs[2] = 8'h00;
    cmd_valid = 1'b1; cmd_op = 4'd5; cmd_use_imm = 1'b1; cmd_imm = 8'hAA; cmd_dst = 2'd2;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1; cmd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk("abort_ready", cmd_ready, 1);
    chk("abort_alu_n", alu_n, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", rsp_valid, 0);
    end
    rd_addr = 2'd2;
    #1 chk("abort_r2", rd_data, mregs[2]);
    chk("abort_status", status_cc, mstatus);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
